// File: rtl/uart_host_link_if.sv
// -----------------------------------------------------------------------------
// uart_host_link_if
//
// Groups the command, UART byte and reply-frame signals of uart_host_link.
// The link itself sits on the "slave" modport. Whatever issues commands,
// emulates uart_tx/uart_rx and consumes frames sits on the "master" modport.
//
// Signals
//   i_CMD[15:0]     command: [15:8] opcode, [7:0] register address
//   i_CMD_VALID     command valid
//   o_CMD_READY     command accepted when high together with i_CMD_VALID
//   o_TX_BYTE[7:0]  byte handed to uart_tx
//   o_TX_DV         one-cycle strobe to uart_tx
//   i_TX_DONE       uart_tx byte-complete strobe
//   i_RX_BYTE[7:0]  byte from uart_rx
//   i_RX_DV         uart_rx byte-valid strobe
//   o_FRAME[39:0]   last complete frame, left-justified, header in [39:32]
//   o_FRAME_VALID   one-cycle strobe, new o_FRAME
//   o_FRAME_ERR     one-cycle strobe, partial frame dropped on timeout
// -----------------------------------------------------------------------------
interface uart_host_link_if;
    logic [15:0] i_CMD;
    logic        i_CMD_VALID;
    logic        o_CMD_READY;
    logic [7:0]  o_TX_BYTE;
    logic        o_TX_DV;
    logic        i_TX_DONE;
    logic [7:0]  i_RX_BYTE;
    logic        i_RX_DV;
    logic [39:0] o_FRAME;
    logic        o_FRAME_VALID;
    logic        o_FRAME_ERR;

    modport slave (
        input  i_CMD,
        input  i_CMD_VALID,
        output o_CMD_READY,
        output o_TX_BYTE,
        output o_TX_DV,
        input  i_TX_DONE,
        input  i_RX_BYTE,
        input  i_RX_DV,
        output o_FRAME,
        output o_FRAME_VALID,
        output o_FRAME_ERR
    );

    modport master (
        output i_CMD,
        output i_CMD_VALID,
        input  o_CMD_READY,
        input  o_TX_BYTE,
        input  o_TX_DV,
        output i_TX_DONE,
        output i_RX_BYTE,
        output i_RX_DV,
        input  o_FRAME,
        input  o_FRAME_VALID,
        input  o_FRAME_ERR
    );
endinterface

// File: rtl/uart_host_link.sv
// -----------------------------------------------------------------------------
// uart_host_link
//
// Host-side end of the sensor-board UART byte protocol.
//   TX path: accepts one command at a time and serialises it to uart_tx as
//            'R'/'S' (opcode only) or 'm'/'a' (opcode, then address). Each byte
//            is strobed once and the next one waits for uart_tx's done strobe.
//   RX path: reassembles reply frames from uart_rx ('A' = 5 bytes,
//            'M'/'m'/'a' = 3 bytes) into a left-justified 40-bit word. A frame
//            that stalls longer than TIMEOUT_CLKS between bytes is dropped.
//   Both paths are independent and may run concurrently.
//
// Parameters
//   TIMEOUT_CLKS  max idle clocks between bytes of one frame (2..65535)
//
// Ports
//   i_CLK   clock
//   i_RST   asynchronous, active-high reset
//   bus     uart_host_link_if.slave (command, uart_tx, uart_rx, frame signals)
//
// TX FSM
//   state    | meaning
//   TX_IDLE  | ready for a command; unknown opcodes are consumed and dropped
//   TX_SEND  | register the next byte and strobe o_TX_DV for one cycle
//   TX_WAIT  | wait for i_TX_DONE, then send the next byte or return to idle
//
// RX FSM
//   state      | meaning
//   RX_IDLE    | waiting for a header byte; anything else is ignored
//   RX_COLLECT | filling byte lanes until the frame length is reached
// -----------------------------------------------------------------------------
module uart_host_link #(
    parameter int unsigned TIMEOUT_CLKS = 65535
) (
    input  logic               i_CLK,
    input  logic               i_RST,
    uart_host_link_if.slave    bus
);

    localparam logic [7:0]  OP_R      = 8'h52;
    localparam logic [7:0]  OP_S      = 8'h53;
    localparam logic [7:0]  OP_M_LO   = 8'h6D;
    localparam logic [7:0]  OP_A_LO   = 8'h61;
    localparam logic [7:0]  HDR_A     = 8'h41;
    localparam logic [7:0]  HDR_M     = 8'h4D;
    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT_CLKS);

    // -------------------------------------------------------------------------
    // TX path
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_WAIT = 2'd2
    } tx_state_e;

    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] cmd_q,      cmd_d;
    logic [1:0]  tx_len_q,   tx_len_d;
    logic [1:0]  tx_idx_q,   tx_idx_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic [7:0]  tx_byte_q,  tx_byte_d;
    logic        tx_dv_q,    tx_dv_d;
    logic [7:0]  cmd_op;

    assign cmd_op = bus.i_CMD[15:8];

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            tx_state_q  <= TX_IDLE;
            cmd_q       <= '0;
            tx_len_q    <= '0;
            tx_idx_q    <= '0;
            cmd_ready_q <= 1'b0;
            tx_byte_q   <= '0;
            tx_dv_q     <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            cmd_q       <= cmd_d;
            tx_len_q    <= tx_len_d;
            tx_idx_q    <= tx_idx_d;
            cmd_ready_q <= cmd_ready_d;
            tx_byte_q   <= tx_byte_d;
            tx_dv_q     <= tx_dv_d;
        end
    end

    always_comb begin
        tx_state_d  = tx_state_q;
        cmd_d       = cmd_q;
        tx_len_d    = tx_len_q;
        tx_idx_d    = tx_idx_q;
        cmd_ready_d = cmd_ready_q;
        tx_byte_d   = tx_byte_q;
        tx_dv_d     = 1'b0;

        case (tx_state_q)
            TX_IDLE: begin
                // Ready is registered, so it comes up one cycle after reset
                // release and stays high while unknown opcodes are dropped.
                cmd_ready_d = 1'b1;
                if (bus.i_CMD_VALID && cmd_ready_q) begin
                    if (cmd_op == OP_R || cmd_op == OP_S) begin
                        cmd_d       = bus.i_CMD;
                        tx_len_d    = 2'd1;
                        tx_idx_d    = 2'd0;
                        cmd_ready_d = 1'b0;
                        tx_state_d  = TX_SEND;
                    end else if (cmd_op == OP_M_LO || cmd_op == OP_A_LO) begin
                        cmd_d       = bus.i_CMD;
                        tx_len_d    = 2'd2;
                        tx_idx_d    = 2'd0;
                        cmd_ready_d = 1'b0;
                        tx_state_d  = TX_SEND;
                    end
                end
            end

            TX_SEND: begin
                tx_byte_d  = (tx_idx_q == 2'd0) ? cmd_q[15:8] : cmd_q[7:0];
                tx_dv_d    = 1'b1;
                tx_idx_d   = tx_idx_q + 2'd1;
                tx_state_d = TX_WAIT;
            end

            TX_WAIT: begin
                if (bus.i_TX_DONE) begin
                    if (tx_idx_q < tx_len_q) begin
                        tx_state_d = TX_SEND;
                    end else begin
                        cmd_ready_d = 1'b1;
                        tx_state_d  = TX_IDLE;
                    end
                end
            end

            default: begin
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    assign bus.o_CMD_READY = cmd_ready_q;
    assign bus.o_TX_BYTE   = tx_byte_q;
    assign bus.o_TX_DV     = tx_dv_q;

    // -------------------------------------------------------------------------
    // RX path
    // -------------------------------------------------------------------------
    typedef enum logic {
        RX_IDLE    = 1'b0,
        RX_COLLECT = 1'b1
    } rx_state_e;

    rx_state_e   rx_state_q, rx_state_d;
    logic [39:0] shift_q,    shift_d;
    logic [2:0]  rx_cnt_q,   rx_cnt_d;
    logic [2:0]  rx_len_q,   rx_len_d;
    logic [15:0] gap_q,      gap_d;
    logic [39:0] frame_q,    frame_d;
    logic        frame_valid_q, frame_valid_d;
    logic        frame_err_q,   frame_err_d;
    logic [39:0] shift_ins;
    logic [2:0]  rx_cnt_inc;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            rx_state_q    <= RX_IDLE;
            shift_q       <= '0;
            rx_cnt_q      <= '0;
            rx_len_q      <= '0;
            gap_q         <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            rx_state_q    <= rx_state_d;
            shift_q       <= shift_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_len_q      <= rx_len_d;
            gap_q         <= gap_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    // Incoming byte placed in the next lower lane; the count of bytes already
    // held selects the lane, so the header always stays in [39:32].
    always_comb begin
        shift_ins = shift_q;
        case (rx_cnt_q)
            3'd1:    shift_ins[31:24] = bus.i_RX_BYTE;
            3'd2:    shift_ins[23:16] = bus.i_RX_BYTE;
            3'd3:    shift_ins[15:8]  = bus.i_RX_BYTE;
            3'd4:    shift_ins[7:0]   = bus.i_RX_BYTE;
            default: shift_ins        = shift_q;
        endcase
    end

    assign rx_cnt_inc = rx_cnt_q + 3'd1;

    always_comb begin
        rx_state_d    = rx_state_q;
        shift_d       = shift_q;
        rx_cnt_d      = rx_cnt_q;
        rx_len_d      = rx_len_q;
        gap_d         = gap_q;
        frame_d       = frame_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                gap_d = '0;
                if (bus.i_RX_DV) begin
                    // Lower lanes are cleared here so a 3-byte frame leaves
                    // [15:0] at zero without extra masking on completion.
                    if (bus.i_RX_BYTE == HDR_A) begin
                        shift_d    = {bus.i_RX_BYTE, 32'h0};
                        rx_cnt_d   = 3'd1;
                        rx_len_d   = 3'd5;
                        rx_state_d = RX_COLLECT;
                    end else if (bus.i_RX_BYTE == HDR_M   ||
                                 bus.i_RX_BYTE == OP_M_LO ||
                                 bus.i_RX_BYTE == OP_A_LO) begin
                        shift_d    = {bus.i_RX_BYTE, 32'h0};
                        rx_cnt_d   = 3'd1;
                        rx_len_d   = 3'd3;
                        rx_state_d = RX_COLLECT;
                    end
                end
            end

            RX_COLLECT: begin
                // A byte takes priority over a timeout landing in the same
                // cycle; header values mid-frame are plain data.
                if (bus.i_RX_DV) begin
                    shift_d  = shift_ins;
                    rx_cnt_d = rx_cnt_inc;
                    gap_d    = '0;
                    if (rx_cnt_inc == rx_len_q) begin
                        frame_d       = shift_ins;
                        frame_valid_d = 1'b1;
                        rx_state_d    = RX_IDLE;
                    end
                end else if (gap_q >= TIMEOUT_C) begin
                    // Counter sat at the limit for a full cycle with no byte:
                    // the error lands TIMEOUT_CLKS+1 cycles after the last byte.
                    frame_err_d = 1'b1;
                    shift_d     = '0;
                    rx_cnt_d    = '0;
                    gap_d       = '0;
                    rx_state_d  = RX_IDLE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end

            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    assign bus.o_FRAME       = frame_q;
    assign bus.o_FRAME_VALID = frame_valid_q;
    assign bus.o_FRAME_ERR   = frame_err_q;

endmodule

// File: tb/tb_uart_host_link.sv
module tb_uart_host_link;

    logic clk;
    logic rst;

    uart_host_link_if bus();

    uart_host_link #(.TIMEOUT_CLKS(100)) dut (
        .i_CLK (clk),
        .i_RST (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Pulse counters sampled on the falling edge, away from the active edge.
    int tx_cnt = 0;
    int fv_cnt = 0;
    int fe_cnt = 0;

    always @(negedge clk) begin
        if (bus.o_TX_DV)       tx_cnt++;
        if (bus.o_FRAME_VALID) fv_cnt++;
        if (bus.o_FRAME_ERR)   fe_cnt++;
    end

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_send(input logic [7:0] b);
        bus.i_RX_BYTE = b;
        bus.i_RX_DV   = 1'b1;
        tick();
        bus.i_RX_DV   = 1'b0;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!bus.o_CMD_READY && k < 50) begin
            tick();
            k++;
        end
        chk("ready_wait", 40'(bus.o_CMD_READY), 40'd1);
    endtask

    task automatic issue_cmd(input logic [15:0] c);
        bus.i_CMD       = c;
        bus.i_CMD_VALID = 1'b1;
        tick();
        bus.i_CMD_VALID = 1'b0;
    endtask

    task automatic done_pulse();
        bus.i_TX_DONE = 1'b1;
        tick();
        bus.i_TX_DONE = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 40'(bus.o_CMD_READY),   40'd0);
        chk({tag, "_txb"},   40'(bus.o_TX_BYTE),     40'd0);
        chk({tag, "_txdv"},  40'(bus.o_TX_DV),       40'd0);
        chk({tag, "_frame"}, bus.o_FRAME,            40'd0);
        chk({tag, "_fv"},    40'(bus.o_FRAME_VALID), 40'd0);
        chk({tag, "_fe"},    40'(bus.o_FRAME_ERR),   40'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int f0;
        int e0;
        logic seen;

        rst             = 1'b1;
        bus.i_CMD       = '0;
        bus.i_CMD_VALID = 1'b0;
        bus.i_TX_DONE   = 1'b0;
        bus.i_RX_BYTE   = '0;
        bus.i_RX_DV     = 1'b0;

        tick();
        tick();
        chk_reset_vals("rst");
        rst = 1'b0;
        tick();
        chk("ready_after_rst", 40'(bus.o_CMD_READY), 40'd1);

        // 'R' command: single byte
        t0 = tx_cnt;
        issue_cmd(16'h5200);
        chk("r_ready_low", 40'(bus.o_CMD_READY), 40'd0);
        tick();
        chk("r_dv", 40'(bus.o_TX_DV), 40'd1);
        chk("r_byte", 40'(bus.o_TX_BYTE), 40'h52);
        tick();
        chk("r_dv_one", 40'(bus.o_TX_DV), 40'd0);
        tick();
        tick();
        chk("r_ready_wait", 40'(bus.o_CMD_READY), 40'd0);
        done_pulse();
        chk("r_ready_back", 40'(bus.o_CMD_READY), 40'd1);
        chk("r_strobes", 40'(tx_cnt - t0), 40'd1);

        // 'm' command: opcode then address
        t0 = tx_cnt;
        issue_cmd(16'h6D1A);
        tick();
        chk("m_byte0", 40'(bus.o_TX_BYTE), 40'h6D);
        chk("m_dv0", 40'(bus.o_TX_DV), 40'd1);
        tick();
        tick();
        done_pulse();
        chk("m_gap_dv", 40'(bus.o_TX_DV), 40'd0);
        chk("m_ready_mid", 40'(bus.o_CMD_READY), 40'd0);
        tick();
        chk("m_dv1", 40'(bus.o_TX_DV), 40'd1);
        chk("m_byte1", 40'(bus.o_TX_BYTE), 40'h1A);
        tick();
        tick();
        chk("m_ready_before_done", 40'(bus.o_CMD_READY), 40'd0);
        done_pulse();
        chk("m_ready_back", 40'(bus.o_CMD_READY), 40'd1);
        chk("m_strobes", 40'(tx_cnt - t0), 40'd2);

        // stray done while idle is ignored
        done_pulse();
        tick();
        chk("idle_done_ready", 40'(bus.o_CMD_READY), 40'd1);
        chk("idle_done_strobes", 40'(tx_cnt - t0), 40'd2);

        // unknown opcode dropped
        t0 = tx_cnt;
        issue_cmd(16'h7700);
        chk("bad_ready", 40'(bus.o_CMD_READY), 40'd1);
        tick();
        tick();
        tick();
        chk("bad_strobes", 40'(tx_cnt - t0), 40'd0);

        // 5-byte 'A' frame, then back-to-back 'M' frame
        f0 = fv_cnt;
        rx_send(8'h41);
        rx_send(8'h01);
        rx_send(8'h02);
        rx_send(8'h03);
        chk("a_no_early_fv", 40'(bus.o_FRAME_VALID), 40'd0);
        rx_send(8'h04);
        chk("a_fv", 40'(bus.o_FRAME_VALID), 40'd1);
        chk("a_frame", bus.o_FRAME, 40'h41_01_02_03_04);
        rx_send(8'h4D);
        chk("a_fv_single", 40'(bus.o_FRAME_VALID), 40'd0);
        tick();
        tick();
        rx_send(8'hAA);
        tick();
        rx_send(8'hBB);
        chk("m3_fv", 40'(bus.o_FRAME_VALID), 40'd1);
        chk("m3_frame", bus.o_FRAME, 40'h4D_AA_BB_00_00);
        tick();
        chk("rx_fv_count", 40'(fv_cnt - f0), 40'd2);

        // timeout after 41 11 22
        e0 = fe_cnt;
        f0 = fv_cnt;
        rx_send(8'h41);
        rx_send(8'h11);
        rx_send(8'h22);
        seen = 1'b0;
        repeat (100) begin
            tick();
            if (bus.o_FRAME_ERR) seen = 1'b1;
        end
        chk("to_not_early", 40'(seen), 40'd0);
        tick();
        chk("to_err", 40'(bus.o_FRAME_ERR), 40'd1);
        chk("to_frame_kept", bus.o_FRAME, 40'h4D_AA_BB_00_00);
        tick();
        chk("to_err_single", 40'(fe_cnt - e0), 40'd1);
        chk("to_no_fv", 40'(fv_cnt - f0), 40'd0);
        rx_send(8'h6D);
        rx_send(8'h00);
        rx_send(8'h05);
        chk("after_to_frame", bus.o_FRAME, 40'h6D_00_05_00_00);

        // byte arriving the same cycle the gap counter is at the limit wins;
        // header values mid-frame are data
        e0 = fe_cnt;
        rx_send(8'h41);
        repeat (100) tick();
        rx_send(8'h4D);
        chk("edge_no_err", 40'(bus.o_FRAME_ERR), 40'd0);
        rx_send(8'h00);
        rx_send(8'h41);
        rx_send(8'hFF);
        chk("edge_fv", 40'(bus.o_FRAME_VALID), 40'd1);
        chk("edge_frame", bus.o_FRAME, 40'h41_4D_00_41_FF);
        tick();
        chk("edge_err_count", 40'(fe_cnt - e0), 40'd0);

        // non-header byte ignored silently
        e0 = fe_cnt;
        f0 = fv_cnt;
        rx_send(8'h12);
        repeat (105) tick();
        chk("nonhdr_no_err", 40'(fe_cnt - e0), 40'd0);
        chk("nonhdr_no_fv", 40'(fv_cnt - f0), 40'd0);
        rx_send(8'h4D);
        rx_send(8'h01);
        rx_send(8'h02);
        chk("nonhdr_frame", bus.o_FRAME, 40'h4D_01_02_00_00);

        // reset during TX_WAIT and during third RX byte
        wait_ready();
        issue_cmd(16'h6D1A);
        tick();
        tick();
        rx_send(8'h61);
        rx_send(8'h10);
        bus.i_RX_BYTE = 8'h20;
        bus.i_RX_DV   = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(posedge clk);
        #1;
        bus.i_RX_DV = 1'b0;
        rst = 1'b0;
        tick();
        f0 = fv_cnt;
        rx_send(8'h20);
        tick();
        chk("no_resume", 40'(fv_cnt - f0), 40'd0);
        chk("no_resume_frame", bus.o_FRAME, 40'd0);

        // concurrent 'S' command and 'a' frame
        wait_ready();
        t0 = tx_cnt;
        bus.i_CMD       = 16'h5300;
        bus.i_CMD_VALID = 1'b1;
        bus.i_RX_BYTE   = 8'h61;
        bus.i_RX_DV     = 1'b1;
        tick();
        bus.i_CMD_VALID = 1'b0;
        bus.i_RX_BYTE   = 8'h10;
        chk("cc_ready_low", 40'(bus.o_CMD_READY), 40'd0);
        tick();
        chk("cc_dv", 40'(bus.o_TX_DV), 40'd1);
        chk("cc_byte", 40'(bus.o_TX_BYTE), 40'h53);
        bus.i_RX_BYTE = 8'h20;
        tick();
        bus.i_RX_DV = 1'b0;
        chk("cc_fv", 40'(bus.o_FRAME_VALID), 40'd1);
        chk("cc_frame", bus.o_FRAME, 40'h61_10_20_00_00);
        chk("cc_dv_off", 40'(bus.o_TX_DV), 40'd0);
        done_pulse();
        chk("cc_ready_back", 40'(bus.o_CMD_READY), 40'd1);
        chk("cc_strobes", 40'(tx_cnt - t0), 40'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
